// File: rtl/bcd_digit_formatter.sv
// Sequential double-dabble binary-to-BCD converter for the eight-digit display.
// It adds saturation and leading-zero blanking, and registers the digit bus so it only changes on completion.
//
// state  | meaning
// IDLE   | waiting for start; digits hold last result
// SHIFT  | one add-3/shift step per cycle, BIN_W steps
// FINISH | saturate, blank, publish digits/ovf, pulse done
module bcd_digit_formatter #(
    parameter int BIN_W    = 27,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [31:0]      digits,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);
    localparam logic [26:0]      MAX_VAL  = 27'd99_999_999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [BIN_W-1:0] sreg;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;

    logic [31:0]      acc_adj;
    logic [31:0]      result;
    logic [31:0]      fmt;

    function automatic logic [31:0] add3(input logic [31:0] a);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < 8; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [31:0] blank_lz(input logic [31:0] a);
        logic [31:0] r;
        logic        lead;
        r    = a;
        lead = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (lead && (a[4*i +: 4] == 4'd0))
                r[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        acc_adj = add3(acc);
        result  = ovf_pend ? 32'h9999_9999 : acc;
        fmt     = BLANK_LZ ? blank_lz(result) : result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            digits   <= 32'hFFFF_FFFF;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg     <= bin;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (27'(bin) > MAX_VAL);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= {acc_adj[30:0], sreg[BIN_W-1]};
                    sreg <= sreg << 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT)
                        state <= FINISH;
                end
                FINISH: begin
                    digits <= fmt;
                    ovf    <= ovf_pend;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Directed bench for bcd_digit_formatter: latency, blanking, saturation, handshake and async reset.
module tb_bcd_digit_formatter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy, done, ovf;
    logic [31:0] digits;
    logic        busy0, done0, ovf0;
    logic [31:0] digits0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] last_exp;

    bcd_digit_formatter #(.BIN_W(27), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .digits(digits), .ovf(ovf)
    );

    bcd_digit_formatter #(.BIN_W(27), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy0), .done(done0), .digits(digits0), .ovf(ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_conv(input logic [26:0] value, input logic [31:0] exp,
                           input logic exp_ovf, input logic [31:0] exp0, input int glitch_at);
        int   lat;
        logic seen, busy_ok, hold_ok;
        lat = 0; seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
        bin   = value;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        for (int n = 1; n <= 40 && !seen; n++) begin
            if (n == glitch_at) begin
                start = 1'b1;
                bin   = 27'd5;
            end else if (n == glitch_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (digits !== last_exp) hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'd28);
        chk("busy_during", 32'(busy_ok), 32'd1);
        chk("digits_held", 32'(hold_ok), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("digits", digits, exp);
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        chk("digits_noblank", digits0, exp0);
        @(posedge clk); #1;
        chk("done_drop", 32'(done), 32'd0);
        last_exp = exp;
    endtask

    task automatic wait_done(output int t, output logic seen);
        seen = 1'b0;
        t    = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
    endtask

    initial begin
        int   t1, t2, t3;
        logic s1, s2, s3, no_done;

        rst = 1'b0; start = 1'b0; bin = '0;
        last_exp = 32'hFFFF_FFFF;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = ~start;
            bin   = 27'd12345;
            chk("reset_outputs", {busy, done, ovf, 29'd0} | 32'(digits != 32'hFFFF_FFFF),
                32'd0);
        end
        chk("reset_digits", digits, 32'hFFFF_FFFF);
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_digits", digits, 32'hFFFF_FFFF);
        chk("idle_busy", 32'(busy), 32'd0);

        do_conv(27'd12345678,  32'h1234_5678, 1'b0, 32'h1234_5678, 0);
        do_conv(27'd5,         32'hFFFF_FFF5, 1'b0, 32'h0000_0005, 0);
        do_conv(27'd0,         32'hFFFF_FFF0, 1'b0, 32'h0000_0000, 0);
        do_conv(27'd100200,    32'hFF10_0200, 1'b0, 32'h0010_0200, 0);
        do_conv(27'd99999999,  32'h9999_9999, 1'b0, 32'h9999_9999, 0);
        do_conv(27'd100000000, 32'h9999_9999, 1'b1, 32'h9999_9999, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_held", 32'(ovf), 32'd1);
        do_conv(27'd7,         32'hFFFF_FFF7, 1'b0, 32'h0000_0007, 0);
        do_conv(27'd12345678,  32'h1234_5678, 1'b0, 32'h1234_5678, 10);

        bin   = 27'd12345678;
        start = 1'b1;
        wait_done(t1, s1);
        wait_done(t2, s2);
        wait_done(t3, s3);
        start = 1'b0;
        chk("b2b_seen", {29'd0, s1, s2, s3}, 32'd7);
        chk("b2b_period1", 32'(t2 - t1), 32'd29);
        chk("b2b_period2", 32'(t3 - t2), 32'd29);
        chk("b2b_digits", digits, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_stopped", 32'(busy), 32'd0);

        bin   = 27'd87654321;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_digits", digits, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        no_done = 1'b1;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk); #1;
            if (done || busy) no_done = 1'b0;
        end
        chk("no_done_after_rst", 32'(no_done), 32'd1);
        chk("digits_after_rst", digits, 32'hFFFF_FFFF);
        last_exp = 32'hFFFF_FFFF;
        do_conv(27'd42, 32'hFFFF_FF42, 1'b0, 32'h0000_0042, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
